// File: rtl/ccm_pkg.sv
// Shared widths, timing constants and FSM state encoding for the CCM counter scheduler.
package ccm_pkg;
  localparam int DEF_WIDTH_NONCE = 100;
  localparam int DEF_WIDTH_FLAG  = 8;
  localparam int DEF_WIDTH_COUNT = 20;
  localparam int DEF_WIDTH_LEN   = 16;
  localparam int DEF_TIMEOUT     = 64;
  localparam int DEF_WIDTH_KEY   = DEF_WIDTH_NONCE + DEF_WIDTH_FLAG + DEF_WIDTH_COUNT;

  // cycles spent in GAP so the core's done-delay counter returns to 0
  localparam int GAP_CYCLES = 2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_GAP   = 3'd4,
    S_XFER  = 3'd5,
    S_ERR   = 3'd6
  } state_e;
endpackage

// File: rtl/ccm_ctr_xor_stage.sv
// Keystream holding register plus zero-latency XOR on the payload valid/ready stream.
module ccm_ctr_xor_stage #(
  parameter int WIDTH_KEY = 128
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ld_i,
  input  logic [WIDTH_KEY-1:0] ks_i,
  input  logic                 xfer_i,
  input  logic                 din_valid_i,
  input  logic [WIDTH_KEY-1:0] din_data_i,
  output logic                 din_ready_o,
  output logic                 dout_valid_o,
  input  logic                 dout_ready_i,
  output logic [WIDTH_KEY-1:0] dout_data_o
);
  logic [WIDTH_KEY-1:0] ks_q;

  // hold the most recent payload keystream block until the next one lands
  always_ff @(posedge clk) begin
    if (!reset)    ks_q <= '0;
    else if (ld_i) ks_q <= ks_i;
  end

  // stream is only open while the scheduler is in its transfer state
  assign dout_valid_o = xfer_i & din_valid_i;
  assign din_ready_o  = xfer_i & dout_ready_i;
  assign dout_data_o  = xfer_i ? (din_data_i ^ ks_q) : '0;
endmodule

// File: rtl/ccm_ctr_sched.sv
// Message-level scheduler: clears the CTR core, fetches S0, then keystream blocks 1..N.
module ccm_ctr_sched
  import ccm_pkg::*;
#(
  parameter int WIDTH_NONCE = DEF_WIDTH_NONCE,
  parameter int WIDTH_FLAG  = DEF_WIDTH_FLAG,
  parameter int WIDTH_COUNT = DEF_WIDTH_COUNT,
  parameter int WIDTH_LEN   = DEF_WIDTH_LEN,
  parameter int TIMEOUT     = DEF_TIMEOUT,
  localparam int WIDTH_KEY  = WIDTH_NONCE + WIDTH_FLAG + WIDTH_COUNT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [WIDTH_NONCE-1:0] cfg_nonce,
  input  logic [WIDTH_FLAG-1:0]  cfg_flag,
  input  logic [WIDTH_LEN-1:0]   cfg_num_blk,
  output logic                   core_clr,
  output logic                   core_req,
  output logic [WIDTH_NONCE-1:0] core_nonce,
  output logic [WIDTH_FLAG-1:0]  core_flag,
  input  logic                   core_done,
  input  logic [WIDTH_KEY-1:0]   core_data,
  input  logic                   din_valid,
  output logic                   din_ready,
  input  logic [WIDTH_KEY-1:0]   din_data,
  output logic                   dout_valid,
  input  logic                   dout_ready,
  output logic [WIDTH_KEY-1:0]   dout_data,
  output logic                   dout_last,
  output logic [WIDTH_KEY-1:0]   s0_data,
  output logic                   s0_valid,
  output logic                   busy,
  output logic                   err_timeout
);
  localparam int TW = $clog2(TIMEOUT + 1);

  state_e                 state_q;
  logic [WIDTH_LEN-1:0]   blk_q, num_q;
  logic [TW-1:0]          timer_q;
  logic [1:0]             gap_q;
  logic [WIDTH_NONCE-1:0] nonce_q;
  logic [WIDTH_FLAG-1:0]  flag_q;
  logic [WIDTH_KEY-1:0]   s0_q;
  logic                   s0_valid_q, err_q, clr_q, req_q, cfg_ready_q, busy_q;
  logic                   xfer, ks_ld, fire;

  assign xfer  = (state_q == S_XFER);
  assign ks_ld = (state_q == S_WAIT) & core_done & (blk_q != '0);
  assign fire  = dout_valid & dout_ready;

  ccm_ctr_xor_stage #(.WIDTH_KEY(WIDTH_KEY)) u_xor (
    .clk          (clk),
    .reset        (reset),
    .ld_i         (ks_ld),
    .ks_i         (core_data),
    .xfer_i       (xfer),
    .din_valid_i  (din_valid),
    .din_data_i   (din_data),
    .din_ready_o  (din_ready),
    .dout_valid_o (dout_valid),
    .dout_ready_i (dout_ready),
    .dout_data_o  (dout_data)
  );

  // message FSM; every control output is registered alongside the state it belongs to
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cfg_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      clr_q       <= 1'b0;
      req_q       <= 1'b0;
      s0_valid_q  <= 1'b0;
      err_q       <= 1'b0;
      s0_q        <= '0;
      nonce_q     <= '0;
      flag_q      <= '0;
      num_q       <= '0;
      blk_q       <= '0;
      timer_q     <= '0;
      gap_q       <= '0;
    end else begin
      clr_q <= 1'b0;
      req_q <= 1'b0;
      case (state_q)
        S_IDLE: if (cfg_valid) begin
          nonce_q     <= cfg_nonce;
          flag_q      <= cfg_flag;
          num_q       <= cfg_num_blk;
          blk_q       <= '0;
          s0_valid_q  <= 1'b0;
          err_q       <= 1'b0;
          cfg_ready_q <= 1'b0;
          busy_q      <= 1'b1;
          clr_q       <= 1'b1;
          state_q     <= S_CLR;
        end
        S_CLR: begin
          req_q   <= 1'b1;
          state_q <= S_ISSUE;
        end
        S_ISSUE: begin
          timer_q <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (core_done) begin
            if (blk_q == '0) begin
              s0_q       <= core_data;
              s0_valid_q <= 1'b1;
            end
            gap_q   <= '0;
            state_q <= S_GAP;
          end else if (timer_q == TW'(TIMEOUT - 1)) begin
            state_q <= S_ERR;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        S_GAP: begin
          if (gap_q == 2'(GAP_CYCLES - 1)) begin
            if (blk_q != '0) begin
              state_q <= S_XFER;
            end else if (num_q == '0) begin
              cfg_ready_q <= 1'b1;
              busy_q      <= 1'b0;
              state_q     <= S_IDLE;
            end else begin
              blk_q   <= WIDTH_LEN'(1);
              req_q   <= 1'b1;
              state_q <= S_ISSUE;
            end
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        S_XFER: if (fire) begin
          if (blk_q == num_q) begin
            cfg_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end else begin
            blk_q   <= blk_q + 1'b1;
            req_q   <= 1'b1;
            state_q <= S_ISSUE;
          end
        end
        S_ERR: begin
          err_q       <= 1'b1;
          cfg_ready_q <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: begin
          cfg_ready_q <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign cfg_ready   = cfg_ready_q;
  assign busy        = busy_q;
  assign core_clr    = clr_q;
  assign core_req    = req_q;
  assign core_nonce  = nonce_q;
  assign core_flag   = flag_q;
  assign s0_data     = s0_q;
  assign s0_valid    = s0_valid_q;
  assign err_timeout = err_q;
  assign dout_last   = xfer & (blk_q == num_q);
endmodule

// File: doc/ccm_ctr_sched.md
Name: ccm_ctr_sched

Overview:
- Message-level controller for the CCM counter-mode keystream core (counter block = flag | nonce | 20-bit count, XORed with key, fixed-delay done pulse).
- Per message: clears the core counter, requests counter block 0 and holds S0 for the tag/MAC path, then requests blocks 1..N one at a time.
- XORs each keystream block with the payload on a valid/ready stream.
- Sits between the CCM top-level sequencer (cfg side) and the payload datapath.

Parameters:
- WIDTH_NONCE, 100, nonce width; must match the core.
- WIDTH_FLAG, 8, flag width; must match the core.
- WIDTH_COUNT, 20, core counter width.
- WIDTH_LEN, 16, payload block-count width.
- TIMEOUT, 64, maximum cycles from core_req to core_done before error.
- Derived localparam WIDTH_KEY = WIDTH_NONCE + WIDTH_FLAG + WIDTH_COUNT (128).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- cfg_valid  in  1  message request
- cfg_ready  out  1  high in IDLE only
- cfg_nonce  in  WIDTH_NONCE  message nonce
- cfg_flag  in  WIDTH_FLAG  CTR flag byte
- cfg_num_blk  in  WIDTH_LEN  payload blocks N (0 allowed)
- core_clr  out  1  active-high clear to core reset
- core_req  out  1  single-cycle pulse to core input_en_buf
- core_nonce  out  WIDTH_NONCE  latched nonce, stable for the whole message
- core_flag  out  WIDTH_FLAG  latched flag, stable for the whole message
- core_done  in  1  core encrypt_en
- core_data  in  WIDTH_KEY  core encrypt_data, valid only while core_done=1
- din_valid / din_ready  in/out  1  payload input handshake
- din_data  in  WIDTH_KEY  payload block
- dout_valid / dout_ready  out/in  1  output handshake
- dout_data  out  WIDTH_KEY  din_data ^ keystream
- dout_last  out  1  marks block N
- s0_data  out  WIDTH_KEY  keystream block 0
- s0_valid  out  1  S0 held valid
- busy  out  1  state != IDLE
- err_timeout  out  1  sticky timeout flag

Behaviour:
- Reset (reset=0 at clk edge) forces:
  - state=IDLE.
  - All outputs 0 except cfg_ready=1.
  - s0_data, the keystream register and the counters cleared.
  - This applies mid-message too; the in-flight core result is discarded.
- States: IDLE, CLR, ISSUE, WAIT, GAP, XFER, ERR.
- IDLE:
  - cfg_valid & cfg_ready latches nonce, flag and N.
  - Clears s0_valid and err_timeout, sets blk=0, goes to CLR.
- CLR (1 cycle): core_clr=1. Next state ISSUE. Gives the core one idle cycle to load the buffer with the new nonce.
- ISSUE (1 cycle): core_req=1, timer cleared. Next state WAIT.
- WAIT:
  - Timer increments each cycle.
  - On core_done: capture core_data.
    - blk=0: capture into s0_data, set s0_valid, go to GAP.
    - blk>=1: capture into the keystream register, go to GAP.
  - Timer reaching TIMEOUT-1 without core_done goes to ERR.
- GAP (exactly 2 cycles): lets the core delay counter return to 0. Exit:
  - blk=0 and N=0: go to IDLE.
  - blk=0 and N>0: blk=1, go to ISSUE.
  - blk>=1: go to XFER.
- XFER:
  - dout_valid=din_valid, din_ready=dout_ready (combinational pass-through, zero latency), dout_data=din_data^ks.
  - dout_last=(blk==N).
  - On transfer: blk==N goes to IDLE; otherwise blk+1 and go to ISSUE.
  - Outside XFER, din_ready=0 and dout_valid=0.
- ERR (1 cycle): sets err_timeout, then IDLE. s0_valid is left as is.
- core_req never asserts while a request is outstanding. Exactly one request per core_done.
- Core counter after core_clr is 0, so request k uses count k.
- Widths:
  - blk is WIDTH_LEN bits.
  - N max = 2^WIDTH_LEN-1; the bench limits N < 2^WIDTH_COUNT.
  - No wrap handling is required.
- core_done outside WAIT is ignored.
- cfg_valid outside IDLE is ignored (cfg_ready=0).
- s0_data is held until the next message is accepted.

Decomposition:
- Package ccm_pkg:
  - WIDTH_NONCE, WIDTH_FLAG, WIDTH_COUNT, WIDTH_KEY defaults.
  - State encoding constants.
  - GAP_CYCLES=2.
- One natural sub-module: ccm_ctr_xor_stage (keystream register + XOR + valid/ready pass-through).
- The FSM stays in the top.

Test Plan:
- The bench instantiates the real keystream core (T_DLY=3) with key=0.
- N=0, nonce=0x1, flag=0x59:
  - one core_clr, one core_req.
  - s0_data={0x59, nonce, 20'd0}, s0_valid=1.
  - busy drops 1+1+4+2 cycles after accept; no dout activity.
- N=3, din=0xFF..FF each, dout_ready=1:
  - dout_data = ~{0x59, nonce, k} for k=1,2,3.
  - dout_last only on k=3; 4 core_req pulses total.
- N=2 with dout_ready toggling 1/0 every cycle:
  - no data loss or duplication.
  - din_ready mirrors dout_ready in XFER.
  - core_req is not issued until each transfer completes.
- Core done tied 0:
  - after TIMEOUT=64 cycles in WAIT, err_timeout=1 and state is IDLE.
  - the next accept clears err_timeout.
- reset=0 asserted during WAIT of block 2:
  - the next cycle has all outputs at reset values.
  - a new message restarts at core count 0, with S0 correct.
- cfg_valid held high during a message:
  - only one accept per message.
  - core_nonce is unchanged until IDLE.
